// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN constants and arbitration-field state encoding
// Used by the arbitration transmitter, the bit stuffer and the decoder-side blocks.
package can_pkg;

    // Arbitration-field states, legacy-compatible 3-bit encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SOF     = 3'd1;
    localparam logic [2:0] ST_BASE_ID = 3'd2;
    localparam logic [2:0] ST_SRR     = 3'd3;
    localparam logic [2:0] ST_IDE_B   = 3'd4;
    localparam logic [2:0] ST_EXT_ID  = 3'd5;
    localparam logic [2:0] ST_RTR_B   = 3'd6;
    localparam logic [2:0] ST_FINISH  = 3'd7;

    localparam logic DOMINANT  = 1'b0;
    localparam logic RECESSIVE = 1'b1;

    localparam int BASE_ID_W = 11;
    localparam int EXT_ID_W  = 18;
    localparam int STUFF_LEN = 5;

endpackage

// File: rtl/can_bit_stuffer.sv
// rtl/can_bit_stuffer.sv - CAN bit stuffer with a bit-request handshake
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   init            restart run tracking for a new frame (run=0, last=recessive)
//   bit_req         one bus bit is being emitted this cycle
//   field_bit       next field bit offered by the field transmitter
//   field_ack       field_bit was consumed (no stuff bit inserted this request)
//   bit_out         value to drive for this request
//   is_stuff        the bit emitted on the next request is a stuff bit
//   run_len         consecutive-equal count, including stuff bits
//   last_val        value of the last bit emitted
module can_bit_stuffer #(
    parameter int STUFF_LEN = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       bit_req,
    input  logic       field_bit,
    output logic       field_ack,
    output logic       bit_out,
    output logic       is_stuff,
    output logic [2:0] run_len,
    output logic       last_val
);
    import can_pkg::*;

    logic [2:0] run_q, run_d;
    logic       last_q, last_d;
    logic       pend_q, pend_d;

    assign is_stuff  = pend_q;
    assign bit_out   = pend_q ? ~last_q : field_bit;
    assign field_ack = bit_req & ~pend_q;
    assign run_len   = run_q;
    assign last_val  = last_q;

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        pend_d = pend_q;
        if (init) begin
            run_d  = 3'd0;
            last_d = RECESSIVE;
            pend_d = 1'b0;
        end else if (bit_req) begin
            // A stuff bit always differs from last_q, so it restarts the run at 1.
            run_d  = (bit_out == last_q) ? run_q + 3'd1 : 3'd1;
            last_d = bit_out;
            pend_d = (run_d == 3'(STUFF_LEN));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 3'd0;
            last_q <= RECESSIVE;
            pend_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/can_arbitration_tx.sv
// rtl/can_arbitration_tx.sv - CAN SOF + arbitration field transmitter with stuffing and bus monitoring
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   tx_pt, SP           bit-timing strobes: drive next bit / sample bus bit
//   start               frame request, accepted only when idle
//   IDTFR, IDE, RTR     identifier and frame flags, latched on accepted start
//   rx_bit              sampled bus value (0 = dominant)
//   tx_bit              bus drive value (1 = recessive)
//   busy                frame in progress
//   done, arb_lost,     one-cycle outcome pulses, mutually exclusive
//   bit_err
//   run_len, last_val   stuffing state handed to the control-field transmitter
module can_arbitration_tx #(
    parameter int ID_W      = 29,
    parameter int STUFF_LEN = can_pkg::STUFF_LEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_pt,
    input  logic            SP,
    input  logic            start,
    input  logic [ID_W-1:0] IDTFR,
    input  logic            IDE,
    input  logic            RTR,
    input  logic            rx_bit,
    output logic            tx_bit,
    output logic            busy,
    output logic            done,
    output logic            arb_lost,
    output logic            bit_err,
    output logic [2:0]      run_len,
    output logic            last_val
);
    import can_pkg::*;

    logic [2:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            ide_q, ide_d;
    logic            rtr_q, rtr_d;
    logic            busy_q, busy_d;
    logic            tx_bit_q, tx_bit_d;
    logic            done_q, done_d;
    logic            arb_lost_q, arb_lost_d;
    logic            bit_err_q, bit_err_d;
    // drv_q: a bit of this frame is on the bus, so SP has something to check.
    // chk_q: that bit is SOF or a stuff bit, where any mismatch is a bit error.
    logic            drv_q, drv_d;
    logic            chk_q, chk_d;

    logic [BASE_ID_W-1:0] base_id;
    logic [EXT_ID_W-1:0]  ext_id;
    logic                 field_bit;
    logic                 stf_init;
    logic                 bit_req;
    logic                 field_ack;
    logic                 stf_bit;
    logic                 stf_is_stuff;
    logic                 sp_act;

    assign base_id  = id_q[BASE_ID_W-1:0];
    assign ext_id   = id_q[BASE_ID_W+EXT_ID_W-1:BASE_ID_W];
    assign stf_init = start & ~busy_q;
    assign sp_act   = SP & busy_q & drv_q;
    // SP wins over a coincident tx_pt; FINISH drops any pending stuff bit.
    assign bit_req  = tx_pt & ~SP & busy_q & (state_q != ST_FINISH);

    can_bit_stuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuffer (
        .clk       (clk),
        .rst_n     (reset),
        .init      (stf_init),
        .bit_req   (bit_req),
        .field_bit (field_bit),
        .field_ack (field_ack),
        .bit_out   (stf_bit),
        .is_stuff  (stf_is_stuff),
        .run_len   (run_len),
        .last_val  (last_val)
    );

    always_comb begin
        field_bit = RECESSIVE;
        case (state_q)
            ST_SOF:     field_bit = DOMINANT;
            ST_BASE_ID: field_bit = base_id[cnt_q[3:0]];
            ST_SRR:     field_bit = RECESSIVE;
            ST_IDE_B:   field_bit = ide_q;
            ST_EXT_ID:  field_bit = ext_id[cnt_q];
            ST_RTR_B:   field_bit = rtr_q;
            default:    field_bit = RECESSIVE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        ide_d      = ide_q;
        rtr_d      = rtr_q;
        busy_d     = busy_q;
        tx_bit_d   = tx_bit_q;
        drv_d      = drv_q;
        chk_d      = chk_q;
        done_d     = 1'b0;
        arb_lost_d = 1'b0;
        bit_err_d  = 1'b0;

        if (!busy_q) begin
            if (start) begin
                id_d    = IDTFR;
                ide_d   = IDE;
                rtr_d   = RTR;
                busy_d  = 1'b1;
                state_d = ST_SOF;
                drv_d   = 1'b0;
                chk_d   = 1'b0;
            end
        end else if (sp_act) begin
            if (chk_q ? (rx_bit != tx_bit_q)
                      : (tx_bit_q == DOMINANT && rx_bit == RECESSIVE)) begin
                bit_err_d = 1'b1;
            end else if (tx_bit_q == RECESSIVE && rx_bit == DOMINANT) begin
                arb_lost_d = 1'b1;
            end else if (state_q == ST_FINISH) begin
                done_d = 1'b1;
            end
            if (bit_err_d || arb_lost_d || done_d) begin
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
                tx_bit_d = RECESSIVE;
            end
        end else if (bit_req) begin
            tx_bit_d = stf_bit;
            drv_d    = 1'b1;
            chk_d    = stf_is_stuff | (state_q == ST_SOF);
            if (field_ack) begin
                case (state_q)
                    ST_SOF: begin
                        state_d = ST_BASE_ID;
                        cnt_d   = 5'(BASE_ID_W - 1);
                    end
                    ST_BASE_ID: begin
                        if (cnt_q == 5'd0) state_d = ide_q ? ST_SRR : ST_RTR_B;
                        else               cnt_d   = cnt_q - 5'd1;
                    end
                    ST_SRR:     state_d = ST_IDE_B;
                    ST_IDE_B: begin
                        if (ide_q) begin
                            state_d = ST_EXT_ID;
                            cnt_d   = 5'(EXT_ID_W - 1);
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                    ST_EXT_ID: begin
                        if (cnt_q == 5'd0) state_d = ST_RTR_B;
                        else               cnt_d   = cnt_q - 5'd1;
                    end
                    ST_RTR_B:   state_d = ide_q ? ST_FINISH : ST_IDE_B;
                    default:    state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            id_q       <= '0;
            ide_q      <= 1'b0;
            rtr_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_bit_q   <= RECESSIVE;
            done_q     <= 1'b0;
            arb_lost_q <= 1'b0;
            bit_err_q  <= 1'b0;
            drv_q      <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            ide_q      <= ide_d;
            rtr_q      <= rtr_d;
            busy_q     <= busy_d;
            tx_bit_q   <= tx_bit_d;
            done_q     <= done_d;
            arb_lost_q <= arb_lost_d;
            bit_err_q  <= bit_err_d;
            drv_q      <= drv_d;
            chk_q      <= chk_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign arb_lost = arb_lost_q;
    assign bit_err  = bit_err_q;

endmodule

// File: tb/tb_can_arbitration_tx.sv
// tb/tb_can_arbitration_tx.sv - directed self-checking bench for can_arbitration_tx
module tb_can_arbitration_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_pt;
    logic        SP;
    logic        start;
    logic [28:0] IDTFR;
    logic        IDE;
    logic        RTR;
    logic        rx_bit;
    logic        tx_bit;
    logic        busy;
    logic        done;
    logic        arb_lost;
    logic        bit_err;
    logic [2:0]  run_len;
    logic        last_val;

    int n_checks = 0;
    int n_errors = 0;

    int          nbits;
    logic [63:0] bits;
    logic        saw_done, saw_arb, saw_err;

    logic [38:0] exp_ext;

    always #5 clk = ~clk;

    can_arbitration_tx dut (
        .clk      (clk),
        .reset    (reset),
        .tx_pt    (tx_pt),
        .SP       (SP),
        .start    (start),
        .IDTFR    (IDTFR),
        .IDE      (IDE),
        .RTR      (RTR),
        .rx_bit   (rx_bit),
        .tx_bit   (tx_bit),
        .busy     (busy),
        .done     (done),
        .arb_lost (arb_lost),
        .bit_err  (bit_err),
        .run_len  (run_len),
        .last_val (last_val)
    );

    always @(posedge clk) begin
        assert (!(SP && tx_pt)) else $error("FAIL strobe_overlap: SP and tx_pt in the same cycle");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [28:0] id, input logic ide, input logic rtr);
        @(negedge clk);
        IDTFR = id;
        IDE   = ide;
        RTR   = rtr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One bus bit per slot: tx_pt, capture tx_bit, SP with echoed (or forced) rx_bit.
    // Stops at the first outcome pulse; returns at the negedge where it is visible.
    task automatic run_slots(input int max_slots, input int force_slot,
                             input logic force_val, input int start_slot);
        nbits    = 0;
        bits     = '0;
        saw_done = 1'b0;
        saw_arb  = 1'b0;
        saw_err  = 1'b0;
        for (int s = 1; s <= max_slots; s++) begin
            @(negedge clk);
            tx_pt = 1'b1;
            @(negedge clk);
            tx_pt = 1'b0;
            bits  = {bits[62:0], tx_bit};
            nbits++;
            if (s == start_slot) begin
                start = 1'b1;
                IDTFR = 29'h0;
                IDE   = 1'b0;
                RTR   = 1'b0;
            end
            @(negedge clk);
            start  = 1'b0;
            rx_bit = (s == force_slot) ? force_val : tx_bit;
            SP     = 1'b1;
            @(negedge clk);
            SP       = 1'b0;
            rx_bit   = 1'b1;
            saw_done = done;
            saw_arb  = arb_lost;
            saw_err  = bit_err;
            if (done || arb_lost || bit_err) break;
        end
    endtask

    initial begin
        reset  = 1'b0;
        tx_pt  = 1'b0;
        SP     = 1'b0;
        start  = 1'b0;
        IDTFR  = '0;
        IDE    = 1'b0;
        RTR    = 1'b0;
        rx_bit = 1'b1;
        exp_ext = {1'b0, {6{6'b111110}}, 2'b11};

        #12;
        check_eq("rst_tx_bit",   tx_bit,   1);
        check_eq("rst_busy",     busy,     0);
        check_eq("rst_done",     done,     0);
        check_eq("rst_arb_lost", arb_lost, 0);
        check_eq("rst_bit_err",  bit_err,  0);
        check_eq("rst_run_len",  run_len,  0);
        check_eq("rst_last_val", last_val, 1);
        reset = 1'b1;

        // Standard, all-zero ID
        launch(29'h0, 1'b0, 1'b0);
        check_eq("std0_busy_after_start", busy, 1);
        check_eq("std0_tx_idle_before_pt", tx_bit, 1);
        run_slots(40, 0, 1'b0, 0);
        check_eq("std0_nbits",    nbits, 16);
        check_eq("std0_bits",     bits, 64'(16'b0000010000010000));
        check_eq("std0_done",     saw_done, 1);
        check_eq("std0_run_len",  run_len, 4);
        check_eq("std0_last_val", last_val, 0);
        check_eq("std0_busy_end", busy, 0);
        @(negedge clk);
        check_eq("std0_done_one_cycle", done, 0);

        // Extended, all-ones ID, RTR=1; a start during SRR must be ignored
        launch(29'h1FFFFFFF, 1'b1, 1'b1);
        run_slots(60, 0, 1'b0, 15);
        check_eq("ext1_nbits",    nbits, 39);
        check_eq("ext1_bits",     bits, 64'(exp_ext));
        check_eq("ext1_done",     saw_done, 1);
        check_eq("ext1_run_len",  run_len, 2);
        check_eq("ext1_last_val", last_val, 1);

        // Final five equal bits: pending stuff bit is dropped, run_len=5 handed off
        launch(29'h7F8, 1'b0, 1'b0);
        run_slots(40, 0, 1'b0, 0);
        check_eq("run5_nbits",    nbits, 15);
        check_eq("run5_bits",     bits, 64'(15'b011111011100000));
        check_eq("run5_done",     saw_done, 1);
        check_eq("run5_run_len",  run_len, 5);
        check_eq("run5_last_val", last_val, 0);

        // Arbitration loss on first ID bit
        launch(29'h400, 1'b0, 1'b0);
        run_slots(40, 2, 1'b0, 0);
        check_eq("arb_nbits",    nbits, 2);
        check_eq("arb_pulse",    saw_arb, 1);
        check_eq("arb_no_done",  saw_done, 0);
        check_eq("arb_no_err",   saw_err, 0);
        check_eq("arb_tx_bit",   tx_bit, 1);
        check_eq("arb_busy",     busy, 0);
        @(negedge clk);
        check_eq("arb_one_cycle", arb_lost, 0);

        // Bit error on SOF, then immediate restart
        launch(29'h0, 1'b0, 1'b0);
        run_slots(40, 1, 1'b1, 0);
        check_eq("sof_err_nbits", nbits, 1);
        check_eq("sof_err_pulse", saw_err, 1);
        check_eq("sof_err_no_arb", saw_arb, 0);
        check_eq("sof_err_busy",  busy, 0);
        IDTFR = 29'h555;
        IDE   = 1'b0;
        RTR   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_busy",   busy, 1);
        check_eq("restart_no_err", bit_err, 0);
        run_slots(40, 0, 1'b0, 0);
        check_eq("restart_nbits",    nbits, 14);
        check_eq("restart_bits",     bits, 64'(14'b01010101010100));
        check_eq("restart_done",     saw_done, 1);
        check_eq("restart_run_len",  run_len, 2);
        check_eq("restart_last_val", last_val, 0);

        // Asynchronous reset in the middle of EXT_ID
        launch(29'h0, 1'b1, 1'b0);
        run_slots(20, 0, 1'b0, 0);
        check_eq("ext0_no_outcome", {saw_done, saw_arb, saw_err}, 0);
        check_eq("ext0_tx_before_rst", tx_bit, 0);
        check_eq("ext0_busy_before_rst", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_rst_tx_bit",   tx_bit, 1);
        check_eq("async_rst_busy",     busy, 0);
        check_eq("async_rst_run_len",  run_len, 0);
        check_eq("async_rst_last_val", last_val, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
